// File: rtl/asym_dpram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asym_dpram_pkg
// Description : Shared types, mode constants and helpers for the asymmetric
//               dual-port RAM controller.
// Revision    : 1.0
// ============================================================================
package asym_dpram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } init_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int PRI_A           = 0;
  localparam int PRI_B           = 1;

  // Ceiling log2; returns 0 for an input of 1 so single-lane builds stay legal.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/asym_dual_port_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : asym_dual_port_ram_ctrl_if
// Description : Wide port A / narrow port B request and response bundle.
// Revision    : 1.0
// ============================================================================
interface asym_dual_port_ram_ctrl_if
  import asym_dpram_pkg::*;
#(
  parameter int WIDTH_B = 8,
  parameter int RATIO   = 2,
  parameter int DEPTH   = 256
);
  localparam int WIDTH_A = WIDTH_B * RATIO;
  localparam int ADDR_B  = clog2(DEPTH);
  localparam int ADDR_A  = clog2(DEPTH / RATIO);

  logic              init_busy;
  logic              collision;
  logic              a_wr_en;
  logic [ADDR_A-1:0] a_w_addr;
  logic [WIDTH_A-1:0] a_indata;
  logic              a_rd_en;
  logic [ADDR_A-1:0] a_r_addr;
  logic [WIDTH_A-1:0] a_outdata;
  logic              a_valid;
  logic              b_wr_en;
  logic [ADDR_B-1:0] b_w_addr;
  logic [WIDTH_B-1:0] b_indata;
  logic              b_rd_en;
  logic [ADDR_B-1:0] b_r_addr;
  logic [WIDTH_B-1:0] b_outdata;
  logic              b_valid;

  modport master (
    output a_wr_en, a_w_addr, a_indata, a_rd_en, a_r_addr,
    output b_wr_en, b_w_addr, b_indata, b_rd_en, b_r_addr,
    input  a_outdata, a_valid, b_outdata, b_valid, init_busy, collision
  );

  modport slave (
    input  a_wr_en, a_w_addr, a_indata, a_rd_en, a_r_addr,
    input  b_wr_en, b_w_addr, b_indata, b_rd_en, b_r_addr,
    output a_outdata, a_valid, b_outdata, b_valid, init_busy, collision
  );

endinterface
`default_nettype wire

// File: rtl/asym_dpram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : asym_dpram_init_ctrl
// Description : Post-reset clear sweep; zeroes one narrow word per cycle.
// Revision    : 1.0
// ============================================================================
module asym_dpram_init_ctrl
  import asym_dpram_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1,
  parameter int ADDR_B         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_en,
  output logic [ADDR_B-1:0] clr_addr,
  output logic              init_busy
);

  init_state_e       r_state;
  init_state_e       w_next;
  logic [ADDR_B-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + ADDR_B'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    clr_en    = 1'b0;
    init_busy = 1'b0;
    case (r_state)
      CLEAR: begin
        clr_en    = 1'b1;
        init_busy = 1'b1;
        if (r_clr_addr == ADDR_B'(DEPTH - 1)) w_next = READY;
      end
      default: w_next = READY;
    endcase
  end

  assign clr_addr = r_clr_addr;

endmodule
`default_nettype wire

// File: rtl/asym_dual_port_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : asym_dual_port_ram_ctrl
// Description : Asymmetric dual-port RAM, wide port A over narrow port B storage.
// Revision    : 1.0
// ============================================================================
module asym_dual_port_ram_ctrl
  import asym_dpram_pkg::*;
#(
  parameter int WIDTH_B        = 8,
  parameter int RATIO          = 2,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = RDW_READ_FIRST,
  parameter int PRIORITY       = PRI_A,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  asym_dual_port_ram_ctrl_if.slave bus
);

  localparam int WIDTH_A = WIDTH_B * RATIO;
  localparam int ADDR_B  = clog2(DEPTH);
  localparam int ADDR_A  = clog2(DEPTH / RATIO);
  localparam int LANE    = clog2(RATIO);

  logic [WIDTH_B-1:0] r_mem [DEPTH];

  logic               w_clr_en;
  logic [ADDR_B-1:0]  w_clr_addr;
  logic               w_busy;
  logic               w_a_wr, w_a_rd, w_b_wr, w_b_rd, w_collide;
  logic [ADDR_A-1:0]  w_a_w_addr, w_a_r_addr;
  logic [ADDR_B-1:0]  w_a_w_base, w_a_r_base;
  logic [WIDTH_A-1:0] w_a_rd_word;
  logic [WIDTH_B-1:0] w_b_rd_word;

  logic               r_a_v1, r_b_v1, r_collision;
  logic [WIDTH_A-1:0] r_a_d1;
  logic [WIDTH_B-1:0] r_b_d1;

  asym_dpram_init_ctrl #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .ADDR_B         (ADDR_B)
  ) u_init_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_en    (w_clr_en),
    .clr_addr  (w_clr_addr),
    .init_busy (w_busy)
  );

  assign w_a_w_addr = bus.a_w_addr;
  assign w_a_r_addr = bus.a_r_addr;
  assign w_a_w_base = ADDR_B'(w_a_w_addr) << LANE;
  assign w_a_r_base = ADDR_B'(w_a_r_addr) << LANE;
  assign w_a_wr     = bus.a_wr_en & ~w_busy;
  assign w_a_rd     = bus.a_rd_en & ~w_busy;
  assign w_b_wr     = bus.b_wr_en & ~w_busy;
  assign w_b_rd     = bus.b_rd_en & ~w_busy;
  assign w_collide  = w_a_wr & w_b_wr & ((bus.b_w_addr >> LANE) == ADDR_B'(w_a_w_addr));

  // Write order encodes priority: the later non-blocking write to a lane wins.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (PRIORITY == PRI_A && w_b_wr) r_mem[bus.b_w_addr] <= bus.b_indata;
      if (w_a_wr) begin
        for (int k = 0; k < RATIO; k++)
          r_mem[w_a_w_base | ADDR_B'(k)] <= bus.a_indata[k*WIDTH_B +: WIDTH_B];
      end
      if (PRIORITY != PRI_A && w_b_wr) r_mem[bus.b_w_addr] <= bus.b_indata;
    end
  end

  always_comb begin
    w_a_rd_word = '0;
    for (int k = 0; k < RATIO; k++)
      w_a_rd_word[k*WIDTH_B +: WIDTH_B] = r_mem[w_a_r_base | ADDR_B'(k)];
    if (RDW_MODE == RDW_WRITE_FIRST && w_a_wr && (w_a_w_addr == w_a_r_addr))
      w_a_rd_word = bus.a_indata;
  end

  // Write-first forwarding on B only for an exact narrow-word match.
  always_comb begin
    w_b_rd_word = r_mem[bus.b_r_addr];
    if (RDW_MODE == RDW_WRITE_FIRST && w_b_wr && (bus.b_w_addr == bus.b_r_addr))
      w_b_rd_word = bus.b_indata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_v1      <= 1'b0;
      r_b_v1      <= 1'b0;
      r_a_d1      <= '0;
      r_b_d1      <= '0;
      r_collision <= 1'b0;
    end else begin
      r_a_v1      <= w_a_rd;
      r_b_v1      <= w_b_rd;
      r_collision <= w_collide;
      if (w_a_rd) r_a_d1 <= w_a_rd_word;
      if (w_b_rd) r_b_d1 <= w_b_rd_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic               r_a_v2, r_b_v2;
      logic [WIDTH_A-1:0] r_a_d2;
      logic [WIDTH_B-1:0] r_b_d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a_v2 <= 1'b0;
          r_b_v2 <= 1'b0;
          r_a_d2 <= '0;
          r_b_d2 <= '0;
        end else begin
          r_a_v2 <= r_a_v1;
          r_b_v2 <= r_b_v1;
          if (r_a_v1) r_a_d2 <= r_a_d1;
          if (r_b_v1) r_b_d2 <= r_b_d1;
        end
      end

      assign bus.a_valid   = r_a_v2;
      assign bus.a_outdata = r_a_d2;
      assign bus.b_valid   = r_b_v2;
      assign bus.b_outdata = r_b_d2;
    end else begin : g_lat1
      assign bus.a_valid   = r_a_v1;
      assign bus.a_outdata = r_a_d1;
      assign bus.b_valid   = r_b_v1;
      assign bus.b_outdata = r_b_d1;
    end
  endgenerate

  assign bus.init_busy = w_busy;
  assign bus.collision = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_asym_dual_port_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_asym_dual_port_ram_ctrl
// Description : Two DUT variants (A-priority/read-first/latency 1 and
//               B-priority/write-first/latency 2) driven with identical stimulus.
// Revision    : 1.0
// ============================================================================
module tb_asym_dual_port_ram_ctrl;
  import asym_dpram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_wr_en, a_rd_en, b_wr_en, b_rd_en;
  logic [6:0] a_w_addr, a_r_addr;
  logic [15:0] a_indata;
  logic [7:0] b_w_addr, b_r_addr, b_indata;

  asym_dual_port_ram_ctrl_if #(.WIDTH_B(8), .RATIO(2), .DEPTH(256)) bus0 ();
  asym_dual_port_ram_ctrl_if #(.WIDTH_B(8), .RATIO(2), .DEPTH(256)) bus1 ();

  assign bus0.a_wr_en  = a_wr_en;   assign bus1.a_wr_en  = a_wr_en;
  assign bus0.a_w_addr = a_w_addr;  assign bus1.a_w_addr = a_w_addr;
  assign bus0.a_indata = a_indata;  assign bus1.a_indata = a_indata;
  assign bus0.a_rd_en  = a_rd_en;   assign bus1.a_rd_en  = a_rd_en;
  assign bus0.a_r_addr = a_r_addr;  assign bus1.a_r_addr = a_r_addr;
  assign bus0.b_wr_en  = b_wr_en;   assign bus1.b_wr_en  = b_wr_en;
  assign bus0.b_w_addr = b_w_addr;  assign bus1.b_w_addr = b_w_addr;
  assign bus0.b_indata = b_indata;  assign bus1.b_indata = b_indata;
  assign bus0.b_rd_en  = b_rd_en;   assign bus1.b_rd_en  = b_rd_en;
  assign bus0.b_r_addr = b_r_addr;  assign bus1.b_r_addr = b_r_addr;

  asym_dual_port_ram_ctrl #(
    .WIDTH_B(8), .RATIO(2), .DEPTH(256), .READ_LATENCY(1),
    .RDW_MODE(RDW_READ_FIRST), .PRIORITY(PRI_A), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  asym_dual_port_ram_ctrl #(
    .WIDTH_B(8), .RATIO(2), .DEPTH(256), .READ_LATENCY(2),
    .RDW_MODE(RDW_WRITE_FIRST), .PRIORITY(PRI_B), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Reference model: byte arrays plus "last read result" per port.
  logic [7:0]  m0 [256];
  logic [7:0]  m1 [256];
  int          busy_cnt;
  logic        e0a_v, e0b_v, e1a_v, e1b_v, p1a_v, p1b_v, e_coll;
  logic [15:0] e0a_d, e1a_d, p1a_d;
  logic [7:0]  e0b_d, e1b_d, p1b_d;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m0[i] = 8'h00;
      m1[i] = 8'h00;
    end
    busy_cnt = 256;
    {e0a_v, e0b_v, e1a_v, e1b_v, p1a_v, p1b_v, e_coll} = '0;
    {e0a_d, e1a_d, p1a_d, e0b_d, e1b_d, p1b_d} = '0;
  endtask

  task automatic idle();
    a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
  endtask

  // Advance one clock: update the model with current inputs, then let the DUT sample them.
  task automatic step();
    logic        busy;
    logic [15:0] ra0, ra1;
    logic [7:0]  rb0, rb1;
    busy = (busy_cnt > 0);
    ra0 = {m0[2*a_r_addr+1], m0[2*a_r_addr]};
    ra1 = {m1[2*a_r_addr+1], m1[2*a_r_addr]};
    if (a_wr_en && a_w_addr == a_r_addr) ra1 = a_indata;
    rb0 = m0[b_r_addr];
    rb1 = (b_wr_en && b_w_addr == b_r_addr) ? b_indata : m1[b_r_addr];
    e_coll = !busy && a_wr_en && b_wr_en && (b_w_addr / 2 == a_w_addr);
    if (!busy) begin
      if (b_wr_en) m0[b_w_addr] = b_indata;
      if (a_wr_en) begin
        m0[2*a_w_addr]   = a_indata[7:0];
        m0[2*a_w_addr+1] = a_indata[15:8];
        m1[2*a_w_addr]   = a_indata[7:0];
        m1[2*a_w_addr+1] = a_indata[15:8];
      end
      if (b_wr_en) m1[b_w_addr] = b_indata;
    end
    e1a_v = p1a_v; if (p1a_v) e1a_d = p1a_d;
    e1b_v = p1b_v; if (p1b_v) e1b_d = p1b_d;
    p1a_v = !busy && a_rd_en; if (p1a_v) p1a_d = ra1;
    p1b_v = !busy && b_rd_en; if (p1b_v) p1b_d = rb1;
    e0a_v = !busy && a_rd_en; if (e0a_v) e0a_d = ra0;
    e0b_v = !busy && b_rd_en; if (e0b_v) e0b_d = rb0;
    if (busy_cnt > 0) busy_cnt--;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    a_w_addr = '0; a_r_addr = '0; a_indata = '0;
    b_w_addr = '0; b_r_addr = '0; b_indata = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus0.a_outdata, bus0.b_outdata, bus0.a_valid, bus0.b_valid, bus0.collision} !== 27'h0) begin
      errors++;
      $display("FAIL reset_out0: got %h expected 0",
               {bus0.a_outdata, bus0.b_outdata, bus0.a_valid, bus0.b_valid, bus0.collision});
    end
    checks++;
    if ({bus1.a_outdata, bus1.b_outdata, bus1.a_valid, bus1.b_valid, bus1.collision} !== 27'h0) begin
      errors++;
      $display("FAIL reset_out1: got %h expected 0",
               {bus1.a_outdata, bus1.b_outdata, bus1.a_valid, bus1.b_valid, bus1.collision});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus0.init_busy !== 1'b1 || bus1.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_release: got %b%b expected 11", bus0.init_busy, bus1.init_busy);
    end
    @(posedge clk);
    #1;
  endtask

  // The edge after the release wait in test_reset already counts as clear cycle 1.
  task automatic test_clear();
    busy_cnt--;
    checks++;
    if (bus0.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy_first: got %b expected 1", bus0.init_busy);
    end
    for (int i = 1; i < 256; i++) begin
      step();
      checks++;
      if (bus0.init_busy !== (i < 255) || bus1.init_busy !== (i < 255)) begin
        errors++;
        $display("FAIL clear_busy cycle %0d: got %b%b expected %b", i + 1,
                 bus0.init_busy, bus1.init_busy, (i < 255));
      end
    end
    for (int i = 0; i < 128; i++) begin
      idle(); a_rd_en = 1'b1; a_r_addr = 7'(i);
      step();
      checks++;
      if (bus0.a_valid !== 1'b1 || bus0.a_outdata !== 16'h0000) begin
        errors++;
        $display("FAIL clear_read0 addr %0d: got v=%b d=%h expected v=1 d=0000", i,
                 bus0.a_valid, bus0.a_outdata);
      end
      if (i > 0) begin
        checks++;
        if (bus1.a_valid !== 1'b1 || bus1.a_outdata !== 16'h0000) begin
          errors++;
          $display("FAIL clear_read1 addr %0d: got v=%b d=%h expected v=1 d=0000", i - 1,
                   bus1.a_valid, bus1.a_outdata);
        end
      end
    end
    idle();
    step();
    checks++;
    if (bus0.a_valid !== 1'b0 || bus1.a_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_tail_valid: got %b%b expected 01", bus0.a_valid, bus1.a_valid);
    end
  endtask

  task automatic test_mapping();
    idle(); a_wr_en = 1'b1; a_w_addr = 7'd5; a_indata = 16'hBEEF;
    step();
    idle(); b_rd_en = 1'b1; b_r_addr = 8'd10;
    step();
    checks++;
    if (bus0.b_valid !== 1'b1 || bus0.b_outdata !== 8'hEF) begin
      errors++;
      $display("FAIL map_b10: got v=%b d=%h expected v=1 d=ef", bus0.b_valid, bus0.b_outdata);
    end
    b_r_addr = 8'd11;
    step();
    checks++;
    if (bus0.b_outdata !== 8'hBE || bus1.b_outdata !== 8'hEF) begin
      errors++;
      $display("FAIL map_b11: got %h/%h expected be/ef", bus0.b_outdata, bus1.b_outdata);
    end
    idle(); b_wr_en = 1'b1; b_w_addr = 8'd20; b_indata = 8'h12;
    step();
    b_w_addr = 8'd21; b_indata = 8'h34;
    step();
    idle(); a_rd_en = 1'b1; a_r_addr = 7'd10;
    step();
    checks++;
    if (bus0.a_valid !== 1'b1 || bus0.a_outdata !== 16'h3412) begin
      errors++;
      $display("FAIL map_a10: got v=%b d=%h expected v=1 d=3412", bus0.a_valid, bus0.a_outdata);
    end
    idle();
    step();
    checks++;
    if (bus1.a_valid !== 1'b1 || bus1.a_outdata !== 16'h3412 ||
        bus0.a_valid !== 1'b0 || bus0.a_outdata !== 16'h3412) begin
      errors++;
      $display("FAIL map_hold: got %b %h / %b %h expected 0 3412 / 1 3412",
               bus0.a_valid, bus0.a_outdata, bus1.a_valid, bus1.a_outdata);
    end
  endtask

  task automatic test_collision();
    idle();
    a_wr_en = 1'b1; a_w_addr = 7'd60; a_indata = 16'h1234;
    b_wr_en = 1'b1; b_w_addr = 8'd120; b_indata = 8'hAA;
    step();
    checks++;
    if (bus0.collision !== 1'b1 || bus1.collision !== 1'b1) begin
      errors++;
      $display("FAIL coll_flag: got %b%b expected 11", bus0.collision, bus1.collision);
    end
    idle(); a_rd_en = 1'b1; a_r_addr = 7'd60;
    step();
    checks++;
    if (bus0.collision !== 1'b0 || bus0.a_outdata !== 16'h1234) begin
      errors++;
      $display("FAIL coll_pri_a: got c=%b d=%h expected c=0 d=1234", bus0.collision, bus0.a_outdata);
    end
    idle();
    step();
    checks++;
    if (bus1.a_outdata !== 16'h12AA) begin
      errors++;
      $display("FAIL coll_pri_b: got %h expected 12aa", bus1.a_outdata);
    end
    a_wr_en = 1'b1; a_w_addr = 7'd61; a_indata = 16'h5678;
    b_wr_en = 1'b1; b_w_addr = 8'd120; b_indata = 8'h55;
    step();
    checks++;
    if (bus0.collision !== 1'b0 || bus1.collision !== 1'b0) begin
      errors++;
      $display("FAIL coll_none: got %b%b expected 00", bus0.collision, bus1.collision);
    end
    idle(); a_rd_en = 1'b1; a_r_addr = 7'd61;
    step();
    checks++;
    if (bus0.a_outdata !== 16'h5678) begin
      errors++;
      $display("FAIL coll_both_a: got %h expected 5678", bus0.a_outdata);
    end
    a_r_addr = 7'd60;
    step();
    checks++;
    if (bus0.a_outdata !== 16'h1255 || bus1.a_outdata !== 16'h5678) begin
      errors++;
      $display("FAIL coll_both_b: got %h/%h expected 1255/5678", bus0.a_outdata, bus1.a_outdata);
    end
    idle();
    step();
  endtask

  task automatic test_rdw();
    idle(); a_wr_en = 1'b1; a_w_addr = 7'd7; a_indata = 16'h1111;
    step();
    a_indata = 16'h2222; a_rd_en = 1'b1; a_r_addr = 7'd7;
    b_rd_en = 1'b1; b_r_addr = 8'd14;
    step();
    checks++;
    if (bus0.a_outdata !== 16'h1111 || bus0.b_outdata !== 8'h11) begin
      errors++;
      $display("FAIL rdw_read_first: got %h/%h expected 1111/11", bus0.a_outdata, bus0.b_outdata);
    end
    idle(); b_wr_en = 1'b1; b_w_addr = 8'd14; b_indata = 8'h77; b_rd_en = 1'b1; b_r_addr = 8'd14;
    step();
    checks++;
    if (bus0.b_outdata !== 8'h22 || bus1.a_outdata !== 16'h2222 || bus1.b_outdata !== 8'h11) begin
      errors++;
      $display("FAIL rdw_mixed: got %h/%h/%h expected 22/2222/11",
               bus0.b_outdata, bus1.a_outdata, bus1.b_outdata);
    end
    idle();
    step();
    checks++;
    if (bus1.b_outdata !== 8'h77) begin
      errors++;
      $display("FAIL rdw_b_write_first: got %h expected 77", bus1.b_outdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [5] = '{16'h0000, 16'hBEEF, 16'h3412, 16'h1255, 16'h1255};
    logic        exp_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0]  addrs [3] = '{7'd5, 7'd10, 7'd60};
    idle();
    step();
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 3) begin
        a_rd_en = 1'b1; a_r_addr = addrs[c];
      end
      step();
      checks++;
      if (bus1.a_valid !== exp_v[c] || (exp_v[c] && bus1.a_outdata !== exp_d[c])) begin
        errors++;
        $display("FAIL lat2 cycle %0d: got v=%b d=%h expected v=%b d=%h", c,
                 bus1.a_valid, bus1.a_outdata, exp_v[c], exp_d[c]);
      end
    end
    checks++;
    if (bus1.a_outdata !== 16'h1255) begin
      errors++;
      $display("FAIL lat2_hold: got %h expected 1255", bus1.a_outdata);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      a_wr_en  = 1'($urandom);   a_rd_en  = 1'($urandom);
      b_wr_en  = 1'($urandom);   b_rd_en  = 1'($urandom);
      a_w_addr = 7'($urandom_range(0, 7));  a_r_addr = 7'($urandom_range(0, 7));
      b_w_addr = 8'($urandom_range(0, 15)); b_r_addr = 8'($urandom_range(0, 15));
      a_indata = 16'($urandom);  b_indata = 8'($urandom);
      // Write-first A read of a word that B also overwrites is left unexercised.
      if (a_wr_en && b_wr_en && (b_w_addr / 2 == a_w_addr) && a_r_addr == a_w_addr)
        a_rd_en = 1'b0;
      step();
      checks++;
      if ({bus0.a_valid, bus0.a_outdata, bus0.b_valid, bus0.b_outdata, bus0.collision, bus0.init_busy}
          !== {e0a_v, e0a_d, e0b_v, e0b_d, e_coll, 1'b0}) begin
        errors++;
        $display("FAIL rand0 n=%0d: got %h expected %h", n,
                 {bus0.a_valid, bus0.a_outdata, bus0.b_valid, bus0.b_outdata, bus0.collision, bus0.init_busy},
                 {e0a_v, e0a_d, e0b_v, e0b_d, e_coll, 1'b0});
      end
      checks++;
      if ({bus1.a_valid, bus1.a_outdata, bus1.b_valid, bus1.b_outdata, bus1.collision, bus1.init_busy}
          !== {e1a_v, e1a_d, e1b_v, e1b_d, e_coll, 1'b0}) begin
        errors++;
        $display("FAIL rand1 n=%0d: got %h expected %h", n,
                 {bus1.a_valid, bus1.a_outdata, bus1.b_valid, bus1.b_outdata, bus1.collision, bus1.init_busy},
                 {e1a_v, e1a_d, e1b_v, e1b_d, e_coll, 1'b0});
      end
    end
    idle();
    step();
    step();
  endtask

  task automatic test_reset_mid_clear();
    idle(); a_wr_en = 1'b1; a_w_addr = 7'd100; a_indata = 16'hCAFE;
    step();
    idle(); a_rd_en = 1'b1; a_r_addr = 7'd100; b_rd_en = 1'b1; b_r_addr = 8'd200;
    step();
    idle();
    step();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus0.a_outdata, bus0.b_outdata, bus1.a_outdata, bus1.b_outdata} !== 48'h0) begin
      errors++;
      $display("FAIL async_reset_data: got %h expected 0",
               {bus0.a_outdata, bus0.b_outdata, bus1.a_outdata, bus1.b_outdata});
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_wr_en = 1'b1; a_w_addr = 7'd100; a_indata = 16'hFFFF;
    b_wr_en = 1'b1; b_w_addr = 8'd201; b_indata = 8'hFF;
    a_rd_en = 1'b1; a_r_addr = 7'd100;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (bus0.init_busy !== 1'b1 || bus0.a_valid !== 1'b0 || bus1.a_valid !== 1'b0) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d: got busy=%b v=%b%b expected 1 00", i,
                 bus0.init_busy, bus0.a_valid, bus1.a_valid);
      end
    end
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step();
      checks++;
      if (bus0.init_busy !== (i < 255) || bus1.init_busy !== (i < 255) || bus0.collision !== 1'b0) begin
        errors++;
        $display("FAIL restart_busy cycle %0d: got %b%b c=%b expected %b c=0", i + 1,
                 bus0.init_busy, bus1.init_busy, bus0.collision, (i < 255));
      end
    end
    idle(); a_rd_en = 1'b1; a_r_addr = 7'd100; b_rd_en = 1'b1; b_r_addr = 8'd201;
    step();
    checks++;
    if (bus0.a_valid !== 1'b1 || bus0.a_outdata !== 16'h0000 || bus0.b_outdata !== 8'h00) begin
      errors++;
      $display("FAIL restart_cleared: got v=%b a=%h b=%h expected v=1 a=0000 b=00",
               bus0.a_valid, bus0.a_outdata, bus0.b_outdata);
    end
    idle();
    step();
    checks++;
    if (bus1.a_outdata !== 16'h0000 || bus1.b_outdata !== 8'h00) begin
      errors++;
      $display("FAIL restart_cleared1: got a=%h b=%h expected 0000/00", bus1.a_outdata, bus1.b_outdata);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_mapping();
    test_collision();
    test_rdw();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
